rca_slice_sequencer: RTL

Multi-cycle add/subtract unit that reuses one narrow ripple-carry slice adder (width SLICE) over WIDTH/SLICE clock cycles to form a full WIDTH-bit result. It trades latency for area in datapaths that cannot afford a full-width adder per operation. Operands are latched on a start pulse. A registered carry links successive slices, LSB slice first. The result is presented with a one-cycle done pulse.

---
 rtl/rca_slice_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/rca_slice_sequencer.sv
// Multi-cycle add/subtract built around one SLICE-bit ripple-carry adder that is
// reused WIDTH/SLICE times, LSB slice first, with a registered carry between passes.

module rca_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  logic [W:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar gi = 0; gi < W; gi++) begin : g_fa
    assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
    assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
  end

  assign o_cout = w_c[W];

endmodule

module rca_slice_sequencer #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [KW-1:0]    r_k;
  logic             r_carry;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;

  logic [SLICE-1:0] w_a_slice;
  logic [SLICE-1:0] w_b_slice;
  logic [SLICE-1:0] w_sum;
  logic             w_slice_cout;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;
  logic             w_ovf;

  assign w_a_slice = r_opa[r_k*SLICE +: SLICE];
  assign w_b_slice = r_opb[r_k*SLICE +: SLICE];

  rca_slice #(
    .W(SLICE)
  ) u_slice (
    .i_a   (w_a_slice),
    .i_b   (w_b_slice),
    .i_cin (r_carry),
    .o_sum (w_sum),
    .o_cout(w_slice_cout)
  );

  // Internal result with the slice currently being computed merged in.
  for (genvar gi = 0; gi < N; gi++) begin : g_res
    localparam logic [KW-1:0] SEL = KW'(gi);
    assign w_res_next[gi*SLICE +: SLICE] = (r_k == SEL) ? w_sum : r_res[gi*SLICE +: SLICE];
  end

  assign w_last = (r_k == K_LAST);
  // Subtraction already folded into opB, so one add-overflow rule covers both ops.
  assign w_ovf  = (r_opa[WIDTH-1] == r_opb[WIDTH-1]) && (w_res_next[WIDTH-1] != r_opa[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_opa   <= A;
            r_opb   <= op ? ~B : B;
            r_carry <= cin ^ op;
            r_k     <= '0;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_res   <= w_res_next;
          r_carry <= w_slice_cout;
          if (w_last) begin
            r_k     <= '0;
            r_s     <= w_res_next;
            r_cout  <= w_slice_cout;
            r_ovf   <= w_ovf;
            r_state <= ST_DONE;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);
  assign S    = r_s;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule
